// File: rtl/femto8_cpu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | femto8_cpu_if : shared 8-bit memory bus of the femto8 CPU            |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
interface femto8_cpu_if;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       write;

  modport master (
    output address,
    output data_out,
    output write,
    input  data_in
  );

  modport slave (
    input  address,
    input  data_out,
    input  write,
    output data_in
  );
endinterface

`default_nettype wire

// File: rtl/femto8_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | femto8_cpu : 8-bit multi-cycle accumulator CPU (A, B, IP, C, Z)      |
// | Option     : FEMTO8_HALT_EN makes opcode 0x80 a HALT                 |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module femto8_cpu #(
  parameter logic [7:0] RESET_VECTOR = 8'h80
) (
  input  wire logic    clk,
  input  wire logic    reset,
  femto8_cpu_if.master bus
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_SELECT  = 3'd1,
    S_DECODE  = 3'd2,
    S_COMPUTE = 3'd3,
    S_READ_IP = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [1:0] c_DST_A    = 2'b00;
  localparam logic [1:0] c_DST_B    = 2'b01;
  localparam logic [1:0] c_DST_IP   = 2'b10;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_a,        w_a_nxt;
  logic [7:0] r_b,        w_b_nxt;
  logic [7:0] r_ip,       w_ip_nxt;
  logic [7:0] r_opcode,   w_opcode_nxt;
  logic [7:0] r_address,  w_address_nxt;
  logic [7:0] r_data_out, w_data_out_nxt;
  logic       r_write,    w_write_nxt;
  logic       r_carry,    w_carry_nxt;
  logic       r_zero,     w_zero_nxt;

  logic [7:0] w_operand;
  logic [8:0] w_alu;
  logic       w_taken;

  assign bus.address  = r_address;
  assign bus.data_out = r_data_out;
  assign bus.write    = r_write;

  // Bit 8 of w_alu is the carry (or borrow) produced by each operation.
  always_comb begin
    w_operand = (r_opcode[7:6] == 2'b00) ? r_b : bus.data_in;
    w_alu     = 9'd0;
    case (r_opcode[3:0])
      4'h0: w_alu = {1'b0, r_a};
      4'h1: w_alu = {1'b0, w_operand};
      4'h2: w_alu = {1'b0, r_a} + 9'd1;
      4'h3: w_alu = {1'b0, r_a} - 9'd1;
      4'h4: w_alu = {r_a, 1'b0};
      4'h5: w_alu = {r_a[0], 1'b0, r_a[7:1]};
      4'h6: w_alu = {r_a, r_carry};
      4'h7: w_alu = {r_a[0], r_carry, r_a[7:1]};
      4'h8: w_alu = {1'b0, r_a | w_operand};
      4'h9: w_alu = {1'b0, r_a & w_operand};
      4'hA: w_alu = {1'b0, r_a ^ w_operand};
      4'hB: w_alu = 9'd0;
      4'hC: w_alu = {1'b0, r_a} + {1'b0, w_operand};
      4'hD: w_alu = {1'b0, r_a} - {1'b0, w_operand};
      4'hE: w_alu = {1'b0, r_a} + {1'b0, w_operand} + {8'd0, r_carry};
      4'hF: w_alu = {1'b0, r_a} - {1'b0, w_operand} - {8'd0, r_carry};
      default: w_alu = 9'd0;
    endcase
  end

  // Branch condition is evaluated on the opcode byte while it is still on data_in.
  assign w_taken = (bus.data_in[0] &  r_carry) | (bus.data_in[1] &  r_zero) |
                   (bus.data_in[2] & ~r_carry) | (bus.data_in[3] & ~r_zero);

  always_comb begin
    w_state_nxt    = r_state;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_ip_nxt       = r_ip;
    w_opcode_nxt   = r_opcode;
    w_address_nxt  = r_address;
    w_data_out_nxt = r_data_out;
    w_write_nxt    = 1'b0;
    w_carry_nxt    = r_carry;
    w_zero_nxt     = r_zero;

    case (r_state)
      S_RESET: begin
        w_ip_nxt    = RESET_VECTOR;
        w_state_nxt = S_SELECT;
      end

      S_SELECT: begin
        w_address_nxt = r_ip;
        w_ip_nxt      = r_ip + 8'd1;
        w_state_nxt   = S_DECODE;
      end

      S_DECODE: begin
        w_opcode_nxt = bus.data_in;
        w_state_nxt  = S_SELECT;
        casez (bus.data_in)
          8'b00??_????: w_state_nxt = S_COMPUTE;
          8'b01??_????: begin
            w_address_nxt = r_ip;
            w_ip_nxt      = r_ip + 8'd1;
            w_state_nxt   = S_COMPUTE;
          end
          8'b11??_????: begin
            w_address_nxt = r_b;
            w_state_nxt   = S_COMPUTE;
          end
          8'b1000_0001: begin
            w_a_nxt = r_b;
            w_b_nxt = r_a;
          end
`ifdef FEMTO8_HALT_EN
          8'b1000_0000: w_state_nxt = S_HALT;
`endif
          8'b1001_????: begin
            w_address_nxt  = {4'b0000, bus.data_in[3:0]};
            w_data_out_nxt = r_a;
            w_write_nxt    = 1'b1;
          end
          8'b1010_????: begin
            if (w_taken) begin
              w_address_nxt = r_ip;
              w_state_nxt   = S_READ_IP;
            end else begin
              w_ip_nxt = r_ip + 8'd1;
            end
          end
          default: w_state_nxt = S_SELECT;
        endcase
      end

      S_COMPUTE: begin
        case (r_opcode[5:4])
          c_DST_A:  w_a_nxt  = w_alu[7:0];
          c_DST_B:  w_b_nxt  = w_alu[7:0];
          c_DST_IP: w_ip_nxt = w_alu[7:0];
          default:  w_a_nxt  = r_a;
        endcase
        w_carry_nxt = w_alu[8];
        w_zero_nxt  = (w_alu[7:0] == 8'd0);
        w_state_nxt = S_SELECT;
      end

      S_READ_IP: begin
        w_ip_nxt    = bus.data_in;
        w_state_nxt = S_SELECT;
      end

      S_HALT: w_state_nxt = S_HALT;

      default: w_state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_RESET;
      r_a        <= 8'd0;
      r_b        <= 8'd0;
      r_ip       <= 8'd0;
      r_opcode   <= 8'd0;
      r_address  <= 8'd0;
      r_data_out <= 8'd0;
      r_write    <= 1'b0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_ip       <= w_ip_nxt;
      r_opcode   <= w_opcode_nxt;
      r_address  <= w_address_nxt;
      r_data_out <= w_data_out_nxt;
      r_write    <= w_write_nxt;
      r_carry    <= w_carry_nxt;
      r_zero     <= w_zero_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_femto8_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_femto8_cpu : program-driven bench, stores scored against a queue  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_femto8_cpu;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  logic       clk;
  logic       reset;
  logic [7:0] mem [256];
  logic [7:0] prog [$];
  wr_t        exp_q [$];
  wr_t        mon_e;
  int         cyc;
  int         errors;
  int         checks;

  femto8_cpu_if bus ();

  femto8_cpu #(.RESET_VECTOR(8'h80)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.data_in = mem[bus.address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.write === 1'b1) mem[bus.address] = bus.data_out;

  // Cycles since reset release; the S_RESET cycle ends at cyc=1.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.write !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL store: got addr=%h data=%h write=%b at cyc %0d, required no store",
                 bus.address, bus.data_out, bus.write, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.address !== mon_e.addr || bus.data_out !== mon_e.data ||
            (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
          errors++;
          $display("FAIL store: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                   bus.address, bus.data_out, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic start();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic load(input logic [7:0] base);
    logic [7:0] a;
    for (int i = 0; i < prog.size(); i++) begin
      a      = base + 8'(i);
      mem[a] = prog[i];
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d, input int c);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic go();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    start();
    @(negedge clk);
    checks++;
    if (bus.write !== 1'b0) begin
      errors++; $display("FAIL reset_write: got %b, required 0", bus.write);
    end
    checks++;
    if (bus.address !== 8'h00) begin
      errors++; $display("FAIL reset_address: got %h, required 00", bus.address);
    end
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++; $display("FAIL reset_data_out: got %h, required 00", bus.data_out);
    end
    prog = '{8'h80, 8'h61, 8'h81};
    load(8'h80);
    go();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.address !== 8'h80) begin
      errors++; $display("FAIL first_fetch: got %h, required 80", bus.address);
    end
    repeat (2) @(negedge clk);
    checks++;
`ifdef FEMTO8_HALT_EN
    if (bus.address !== 8'h80 || bus.write !== 1'b0) begin
      errors++; $display("FAIL halt_hold: got addr=%h write=%b, required 80/0", bus.address, bus.write);
    end
`else
    if (bus.address !== 8'h81) begin
      errors++; $display("FAIL second_fetch: got %h, required 81", bus.address);
    end
`endif
  endtask

  task automatic test_load_add_store();
    start();
    prog = '{8'h41, 8'h05, 8'h51, 8'h03, 8'h0C, 8'h90, 8'h61, 8'h86};
    load(8'h80);
    push(8'h00, 8'h08, 12);
    go();
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL add_store_pending: got %0d stores missing, required 0", exp_q.size());
    end
    checks++;
    if (mem[0] !== 8'h08) begin
      errors++; $display("FAIL add_store_ram: got %h, required 08", mem[0]);
    end
  endtask

  task automatic test_carry_zero();
    start();
    prog = '{8'h41, 8'hFF, 8'h51, 8'h01, 8'h0C, 8'hA1, 8'h90, 8'h41, 8'hEE, 8'h91, 8'h61, 8'h8A};
    load(8'h80);
    prog = '{8'h91, 8'h81, 8'h92, 8'hA2, 8'hA0, 8'h41, 8'h55, 8'h93, 8'h61, 8'h98};
    load(8'h90);
    prog = '{8'h41, 8'hAA, 8'h93, 8'h61, 8'hA3};
    load(8'hA0);
    push(8'h01, 8'h00, 15);
    push(8'h02, 8'h01, -1);
    push(8'h03, 8'hAA, -1);
    go();
    repeat (50) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL carry_zero_pending: got %0d stores missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_branch_not_taken();
    start();
    prog = '{8'h41, 8'h01, 8'hA1, 8'h90, 8'h90, 8'h61, 8'h85};
    load(8'h80);
    prog = '{8'h41, 8'hEE, 8'h90, 8'h61, 8'h93};
    load(8'h90);
    push(8'h00, 8'h01, 8);
    go();
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL not_taken_pending: got %0d stores missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_alu();
    start();
    prog = '{8'h41, 8'hF0, 8'h51, 8'h0F, 8'h08, 8'h90, 8'h09, 8'h91, 8'h0A, 8'h92,
             8'h03, 8'h93, 8'h02, 8'h94, 8'h03, 8'h04, 8'h06, 8'h95, 8'h07, 8'h96,
             8'h05, 8'h97, 8'h4D, 8'h80, 8'h0E, 8'h98, 8'h0F, 8'h99, 8'h0D, 8'h9A,
             8'h12, 8'h3C, 8'h81, 8'h4E, 8'h00, 8'h9B, 8'h0B, 8'h9C, 8'h01, 8'h9D,
             8'h61, 8'hA8};
    load(8'h80);
    push(8'h00, 8'hFF, -1); push(8'h01, 8'h0F, -1); push(8'h02, 8'h00, -1);
    push(8'h03, 8'hFF, -1); push(8'h04, 8'h00, -1); push(8'h05, 8'hFD, -1);
    push(8'h06, 8'hFE, -1); push(8'h07, 8'h7F, -1); push(8'h08, 8'h0F, -1);
    push(8'h09, 8'hFF, -1); push(8'h0A, 8'hF0, -1); push(8'h0B, 8'hF2, -1);
    push(8'h0C, 8'h00, -1); push(8'h0D, 8'hF0, -1);
    go();
    repeat (160) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL alu_pending: got %0d stores missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_jump_indirect();
    start();
    prog = '{8'h61, 8'hA0, 8'h41, 8'hEE, 8'h90, 8'h61, 8'h85};
    load(8'h80);
    prog = '{8'h51, 8'h05, 8'hC1, 8'h90, 8'h3B, 8'hF1, 8'hA2, 8'hC0, 8'hFC, 8'h91,
             8'h81, 8'h92, 8'h61, 8'hAC};
    load(8'hA0);
    prog = '{8'h41, 8'hEE, 8'h91, 8'h61, 8'hC3};
    load(8'hC0);
    mem[5] = 8'h77;
    push(8'h00, 8'h77, 12);
    push(8'h01, 8'h77, -1);
    push(8'h02, 8'h05, -1);
    go();
    repeat (60) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL jump_indirect_pending: got %0d stores missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_ip_wrap();
    start();
    prog = '{8'h61, 8'hFE};
    load(8'h80);
    prog = '{8'h41, 8'h33};
    load(8'hFE);
    prog = '{8'h9F, 8'h61, 8'h01};
    load(8'h00);
    push(8'h0F, 8'h33, 9);
    go();
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL ip_wrap_pending: got %0d stores missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    start();
    prog = '{8'h41, 8'h5A, 8'h90, 8'h61, 8'h83};
    load(8'h80);
    mem[0] = 8'h11;
    go();
    repeat (5) @(negedge clk);
    checks++;
    if (bus.address !== 8'h82) begin
      errors++; $display("FAIL mid_reset_decode_addr: got %h, required 82", bus.address);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.write !== 1'b0 || bus.address !== 8'h00) begin
      errors++; $display("FAIL mid_reset_abort: got write=%b addr=%h, required 0/00", bus.write, bus.address);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mem[0] !== 8'h11) begin
      errors++; $display("FAIL mid_reset_ram: got %h, required 11", mem[0]);
    end
    push(8'h00, 8'h5A, 6);
    go();
    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL mid_reset_restart: got %0d stores missing, required 0", exp_q.size());
    end
    checks++;
    if (mem[0] !== 8'h5A) begin
      errors++; $display("FAIL mid_reset_ram_after: got %h, required 5A", mem[0]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    test_reset();
    test_load_add_store();
    test_carry_zero();
    test_branch_not_taken();
    test_alu();
    test_jump_indirect();
    test_ip_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
